stage_ir_wide: RTL and testbench
================================

Name: stage_ir_wide

Overview:
Parametrised N-wide in-order retire stage. Each cycle it accepts up to RETIRE_WIDTH head entries from the ROB and retires the longest eligible prefix. It drives freelist/maptable retire enables, architectural writeback and the branch-recovery interrupt. Retired stores go into an internal committed-store queue, which drains to Dmem one per granted cycle. A halt FSM holds off HALTED status until every committed store has drained.

Parameters:
RETIRE_WIDTH, 2, retire slots per cycle (slot 0 = oldest)
SQ_DEPTH, 4, committed-store queue entries; power of two, >= RETIRE_WIDTH
PREG_W, 6, physical register tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
head_valid  in  RETIRE_WIDTH  ROB slot i is complete and ready to retire
head_t / head_t_old  in  RETIRE_WIDTH*PREG_W  new and old physical tags per slot
head_dest_idx  in  RETIRE_WIDTH*5  architectural destination per slot
head_result  in  RETIRE_WIDTH*XLEN  ALU result, branch target or store address
head_NPC  in  RETIRE_WIDTH*XLEN  next PC per slot
head_rs2_value  in  RETIRE_WIDTH*XLEN  store data per slot
head_wr_mem / head_take_branch / head_halt  in  RETIRE_WIDTH each  per-slot flags
head_mem_size  in  RETIRE_WIDTH*2  MEM_SIZE per slot
retire_en  out  RETIRE_WIDTH  slot retired this cycle; ROB pop, freelist and maptable enable
retire_t / retire_t_old  out  RETIRE_WIDTH*PREG_W  pass-through of head_t / head_t_old
completed_insts  out  4  popcount(retire_en)
wr_en / wr_idx / wr_data / wr_NPC  out  per-slot  architectural writeback
interrupt  out  1  a retired slot had take_branch
branch_target  out  XLEN  head_result of that slot
st_command  out  2  BUS_STORE or BUS_NONE
st_size / st_addr / st_data  out  2/XLEN/XLEN  queue head entry
st_grant  in  1  Dmem accepts the head store at this edge
sq_empty  out  1  committed-store queue is empty
error_status  out  4  HALTED_ON_WFI or NO_ERROR

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset (reset==0 at a clock edge) sets RUN, SQ count 0, pointers 0, and discards all queued stores.
- Outputs in the reset state: st_command=BUS_NONE, sq_empty=1, error_status=NO_ERROR.
- retire_en is combinational from the head_* inputs and registered state. retire_en[i]=1 iff all of the following hold:
  - state==RUN;
  - head_valid[0..i] are all 1;
  - no slot j<i has head_take_branch or head_halt set;
  - the count of head_wr_mem over slots 0..i is <= SQ_DEPTH-count.
- Same-cycle pop does NOT create enqueue credit.
- A branch or halt slot itself retires; all younger slots are blocked.
- Outputs driven from retire_en:
  - wr_en[i]=retire_en[i] && head_dest_idx[i]!=0.
  - wr_idx, wr_data and wr_NPC pass through from the head_* inputs.
  - interrupt=OR over i of (retire_en[i] && head_take_branch[i]). branch_target comes from the lowest such slot; otherwise it is 0.
- Store queue: each retired slot with wr_mem enqueues {size, addr=head_result, data=head_rs2_value} at the edge, in slot order.
- Enqueue and pop may happen in the same cycle; count updates by (enqueued - popped). Pointers wrap mod SQ_DEPTH.
- st_command=BUS_STORE iff count>0; st_size, st_addr and st_data show the head entry.
  - Head pops at an edge with st_command==BUS_STORE && st_grant.
  - The entry is held unchanged until granted.
  - st_grant with an empty queue is ignored.
- Stores already committed keep draining after an interrupt. The queue is never flushed except by reset.
- FSM transitions:
  - RUN to DRAIN: a retired slot has head_halt.
  - DRAIN to HALTED: count==0, or count==1 && pop this edge.
  - HALTED is sticky until reset. In DRAIN and HALTED, retire_en=0.
- error_status=HALTED_ON_WFI iff state==HALTED.
- Reset mid-drain discards pending stores; the queue is never partially drained across a reset.

Test Plan:
- N=2, both slots valid ALU ops, dest 3 and 0 -> retire_en=2'b11, completed_insts=2, wr_en=2'b01, st_command=BUS_NONE.
- Slot0 take_branch, result 0x1000; slot1 valid -> retire_en=2'b01, interrupt=1, branch_target=0x1000.
- Four store retire pairs with st_grant=0 and SQ_DEPTH=4:
  - First two cycles enqueue 4 stores; the third cycle has retire_en=0 with slot0 a store.
  - Raise st_grant for 1 cycle -> count 3, still 0 retired that cycle.
  - Next cycle slot0 retires.
- Store with addr 0x40, data 0xDEADBEEF, size WORD, then st_grant held high -> BUS_STORE with those fields for 1 cycle, then BUS_NONE and sq_empty=1.
- Halt retired with 2 stores queued, st_grant=0 for 5 cycles:
  - error_status stays NO_ERROR and retire_en=0 while stores remain queued.
  - Grant 2 cycles -> HALTED_ON_WFI on the edge of the 2nd pop.
- reset=0 during DRAIN with 3 queued stores -> next cycle st_command=BUS_NONE, state RUN, normal retire resumes.

Source files
------------

// File: rtl/stage_ir_wide.sv
// N-wide in-order retire stage with a committed-store queue draining to Dmem
// and a halt FSM that waits for all committed stores before reporting HALTED.

module stage_ir_lane #(
   parameter int XLEN = 32
) (
   input  logic            retire,
   input  logic [4:0]      dest_idx,
   input  logic [XLEN-1:0] result,
   input  logic [XLEN-1:0] npc,
   output logic            wr_en,
   output logic [4:0]      wr_idx,
   output logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] wr_npc
);
   // x0 is never written architecturally
   assign wr_en   = retire && (dest_idx != 5'd0);
   assign wr_idx  = dest_idx;
   assign wr_data = result;
   assign wr_npc  = npc;
endmodule

module stage_ir_wide #(
   parameter int RETIRE_WIDTH = 2,
   parameter int SQ_DEPTH     = 4,
   parameter int PREG_W       = 6,
   parameter int XLEN         = 32
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [RETIRE_WIDTH-1:0]                head_valid,
   input  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]    head_t,
   input  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]    head_t_old,
   input  logic [RETIRE_WIDTH-1:0][4:0]           head_dest_idx,
   input  logic [RETIRE_WIDTH-1:0][XLEN-1:0]      head_result,
   input  logic [RETIRE_WIDTH-1:0][XLEN-1:0]      head_NPC,
   input  logic [RETIRE_WIDTH-1:0][XLEN-1:0]      head_rs2_value,
   input  logic [RETIRE_WIDTH-1:0]                head_wr_mem,
   input  logic [RETIRE_WIDTH-1:0]                head_take_branch,
   input  logic [RETIRE_WIDTH-1:0]                head_halt,
   input  logic [RETIRE_WIDTH-1:0][1:0]           head_mem_size,
   output logic [RETIRE_WIDTH-1:0]                retire_en,
   output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]    retire_t,
   output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]    retire_t_old,
   output logic [3:0]                             completed_insts,
   output logic [RETIRE_WIDTH-1:0]                wr_en,
   output logic [RETIRE_WIDTH-1:0][4:0]           wr_idx,
   output logic [RETIRE_WIDTH-1:0][XLEN-1:0]      wr_data,
   output logic [RETIRE_WIDTH-1:0][XLEN-1:0]      wr_NPC,
   output logic                                   interrupt,
   output logic [XLEN-1:0]                        branch_target,
   output logic [1:0]                             st_command,
   output logic [1:0]                             st_size,
   output logic [XLEN-1:0]                        st_addr,
   output logic [XLEN-1:0]                        st_data,
   input  logic                                   st_grant,
   output logic                                   sq_empty,
   output logic [3:0]                             error_status
);
   localparam int CW = $clog2(SQ_DEPTH + 1);
   localparam int PW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(SQ_DEPTH);

   localparam logic [1:0] BUS_NONE      = 2'h0;
   localparam logic [1:0] BUS_STORE     = 2'h2;
   localparam logic [3:0] NO_ERROR      = 4'h0;
   localparam logic [3:0] HALTED_ON_WFI = 4'h2;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   typedef struct packed {
      logic [1:0]      size;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } sq_ent_t;

   state_t                      state, state_n;
   sq_ent_t                     mem [SQ_DEPTH];
   logic [CW-1:0]               count;
   logic [PW-1:0]               head_ptr, tail_ptr;
   logic [CW-1:0]               free, nst, enq_cnt;
   logic                        ok, pop, halt_ret;
   logic [RETIRE_WIDTH-1:0]     enq;
   logic [RETIRE_WIDTH-1:0][PW-1:0] enq_idx;

   assign free = DEPTH_C - count;
   assign pop  = (count != '0) && st_grant;

   // Longest eligible prefix; store credit counts only entries free now
   always_comb begin
      ok        = (state == RUN);
      nst       = '0;
      retire_en = '0;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         ok = ok & head_valid[i];
         if (head_wr_mem[i]) nst = nst + CW'(1);
         ok = ok & (nst <= free);
         retire_en[i] = ok;
         ok = ok & ~head_take_branch[i] & ~head_halt[i];
      end
   end

   always_comb begin
      enq_cnt = '0;
      enq     = '0;
      enq_idx = '0;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         enq[i]     = retire_en[i] & head_wr_mem[i];
         enq_idx[i] = tail_ptr + PW'(enq_cnt);
         if (enq[i]) enq_cnt = enq_cnt + CW'(1);
      end
   end

   always_comb begin
      completed_insts = '0;
      interrupt       = 1'b0;
      branch_target   = '0;
      for (int i = RETIRE_WIDTH - 1; i >= 0; i--) begin
         completed_insts = completed_insts + 4'(retire_en[i]);
         if (retire_en[i] && head_take_branch[i]) begin
            interrupt     = 1'b1;
            branch_target = head_result[i];
         end
      end
   end

   assign halt_ret     = |(retire_en & head_halt);
   assign retire_t     = head_t;
   assign retire_t_old = head_t_old;

   for (genvar g = 0; g < RETIRE_WIDTH; g++) begin : g_lane
      stage_ir_lane #(.XLEN(XLEN)) u_lane (
         .retire   (retire_en[g]),
         .dest_idx (head_dest_idx[g]),
         .result   (head_result[g]),
         .npc      (head_NPC[g]),
         .wr_en    (wr_en[g]),
         .wr_idx   (wr_idx[g]),
         .wr_data  (wr_data[g]),
         .wr_npc   (wr_NPC[g])
      );
   end

   always_comb begin
      state_n = state;
      case (state)
         RUN:     if (halt_ret) state_n = DRAIN;
         DRAIN:   if (count == '0 || (count == CW'(1) && pop)) state_n = HALTED;
         HALTED:  state_n = HALTED;
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= RUN;
         count    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
      end else begin
         state    <= state_n;
         count    <= count + enq_cnt - CW'(pop);
         head_ptr <= head_ptr + PW'(pop);
         tail_ptr <= tail_ptr + PW'(enq_cnt);
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count alone
   always_ff @(posedge clock) begin
      for (int i = 0; i < RETIRE_WIDTH; i++)
         if (reset && enq[i])
            mem[enq_idx[i]] <= '{size: head_mem_size[i], addr: head_result[i],
                                 data: head_rs2_value[i]};
   end

   assign st_command   = (count != '0) ? BUS_STORE : BUS_NONE;
   assign st_size      = mem[head_ptr].size;
   assign st_addr      = mem[head_ptr].addr;
   assign st_data      = mem[head_ptr].data;
   assign sq_empty     = (count == '0);
   assign error_status = (state == HALTED) ? HALTED_ON_WFI : NO_ERROR;
endmodule

// File: tb/tb_stage_ir_wide.sv
// Scoreboard bench for stage_ir_wide: expected stores queued at retire,
// compared against the Dmem port as the DUT presents them.

module tb_stage_ir_wide;
   localparam int RW = 2, SQD = 4, PW = 6, XL = 32;
   localparam logic [1:0] BUS_NONE = 2'h0, BUS_STORE = 2'h2, WORD = 2'h2;
   localparam logic [3:0] NO_ERROR = 4'h0, HALTED_ON_WFI = 4'h2;

   logic clock = 1'b0;
   logic reset;
   logic [RW-1:0]          head_valid, head_wr_mem, head_take_branch, head_halt;
   logic [RW-1:0][PW-1:0]  head_t, head_t_old;
   logic [RW-1:0][4:0]     head_dest_idx;
   logic [RW-1:0][XL-1:0]  head_result, head_NPC, head_rs2_value;
   logic [RW-1:0][1:0]     head_mem_size;
   logic [RW-1:0]          retire_en, wr_en;
   logic [RW-1:0][PW-1:0]  retire_t, retire_t_old;
   logic [3:0]             completed_insts, error_status;
   logic [RW-1:0][4:0]     wr_idx;
   logic [RW-1:0][XL-1:0]  wr_data, wr_NPC;
   logic                   interrupt, st_grant, sq_empty;
   logic [XL-1:0]          branch_target, st_addr, st_data;
   logic [1:0]             st_command, st_size;

   stage_ir_wide #(.RETIRE_WIDTH(RW), .SQ_DEPTH(SQD), .PREG_W(PW), .XLEN(XL)) dut (
      .clock(clock), .reset(reset), .head_valid(head_valid), .head_t(head_t),
      .head_t_old(head_t_old), .head_dest_idx(head_dest_idx), .head_result(head_result),
      .head_NPC(head_NPC), .head_rs2_value(head_rs2_value), .head_wr_mem(head_wr_mem),
      .head_take_branch(head_take_branch), .head_halt(head_halt),
      .head_mem_size(head_mem_size), .retire_en(retire_en), .retire_t(retire_t),
      .retire_t_old(retire_t_old), .completed_insts(completed_insts), .wr_en(wr_en),
      .wr_idx(wr_idx), .wr_data(wr_data), .wr_NPC(wr_NPC), .interrupt(interrupt),
      .branch_target(branch_target), .st_command(st_command), .st_size(st_size),
      .st_addr(st_addr), .st_data(st_data), .st_grant(st_grant), .sq_empty(sq_empty),
      .error_status(error_status)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]    size;
      logic [XL-1:0] addr;
      logic [XL-1:0] data;
   } st_t;
   st_t sbq[$];
   int  total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_heads();
      head_valid = '0; head_wr_mem = '0; head_take_branch = '0; head_halt = '0;
      head_t = '0; head_t_old = '0; head_dest_idx = '0; head_result = '0;
      head_NPC = '0; head_rs2_value = '0; head_mem_size = '0;
   endtask

   task automatic set_slot(input int i, input logic [4:0] dest, input logic [XL-1:0] res,
                           input logic [XL-1:0] rs2, input logic st, input logic br,
                           input logic hlt, input logic [1:0] sz);
      head_valid[i] = 1'b1; head_dest_idx[i] = dest; head_result[i] = res;
      head_rs2_value[i] = rs2; head_wr_mem[i] = st; head_take_branch[i] = br;
      head_halt[i] = hlt; head_mem_size[i] = sz;
      head_t[i] = PW'(i + 10); head_t_old[i] = PW'(i + 20); head_NPC[i] = res + 4;
   endtask

   // Check store port against the scoreboard head, then retire outcome, then clock
   task automatic cyc(input logic [RW-1:0] exp_ret);
      #1;
      chk("st_cmd", st_command, (sbq.size() > 0) ? BUS_STORE : BUS_NONE);
      chk("sq_empty", sq_empty, sbq.size() == 0);
      if (sbq.size() > 0) begin
         chk("st_addr", st_addr, sbq[0].addr);
         chk("st_data", st_data, sbq[0].data);
         chk("st_size", st_size, sbq[0].size);
         if (st_grant) void'(sbq.pop_front());
      end
      chk("retire", retire_en, exp_ret);
      chk("completed", completed_insts, 64'($countones(exp_ret)));
      for (int i = 0; i < RW; i++)
         if (exp_ret[i] && head_wr_mem[i])
            sbq.push_back('{head_mem_size[i], head_result[i], head_rs2_value[i]});
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; st_grant = 1'b0;
      clear_heads();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_cmd", st_command, BUS_NONE);
      chk("rst_empty", sq_empty, 1);
      chk("rst_err", error_status, NO_ERROR);
      reset = 1'b1;

      // two ALU ops, one to x0
      clear_heads();
      set_slot(0, 5'd3, 32'h11, 0, 0, 0, 0, 0);
      set_slot(1, 5'd0, 32'h22, 0, 0, 0, 0, 0);
      #1;
      chk("wr_en", wr_en, 2'b01);
      chk("wr_data0", wr_data[0], 32'h11);
      chk("intr0", interrupt, 0);
      chk("rt_t1", retire_t[1], 6'd11);
      cyc(2'b11);

      // branch in slot 0 blocks slot 1
      clear_heads();
      set_slot(0, 5'd1, 32'h1000, 0, 0, 1, 0, 0);
      set_slot(1, 5'd2, 32'h2000, 0, 0, 0, 0, 0);
      #1;
      chk("intr", interrupt, 1);
      chk("br_tgt", branch_target, 32'h1000);
      cyc(2'b01);

      // fill the store queue, then credit only after a pop
      clear_heads();
      for (int c = 0; c < 2; c++) begin
         set_slot(0, 0, 32'h100 + 32'(c * 8), 32'hA0 + 32'(c), 1, 0, 0, WORD);
         set_slot(1, 0, 32'h104 + 32'(c * 8), 32'hB0 + 32'(c), 1, 0, 0, 2'h1);
         cyc(2'b11);
      end
      set_slot(0, 0, 32'h200, 32'hC0, 1, 0, 0, WORD);
      set_slot(1, 0, 32'h204, 32'hC1, 1, 0, 0, WORD);
      cyc(2'b00);
      st_grant = 1'b1;
      cyc(2'b00);
      st_grant = 1'b0;
      cyc(2'b01);
      clear_heads();
      st_grant = 1'b1;
      repeat (4) cyc(2'b00);
      chk("drained", sq_empty, 1);

      // single word store
      st_grant = 1'b0;
      set_slot(0, 0, 32'h40, 32'hDEADBEEF, 1, 0, 0, WORD);
      cyc(2'b01);
      clear_heads();
      st_grant = 1'b1;
      #1;
      chk("w_addr", st_addr, 32'h40);
      chk("w_data", st_data, 32'hDEADBEEF);
      cyc(2'b00);
      chk("w_cmd_after", st_command, BUS_NONE);
      chk("w_empty_after", sq_empty, 1);

      // halt with two queued stores
      st_grant = 1'b0;
      set_slot(0, 0, 32'h300, 32'h5, 1, 0, 0, WORD);
      set_slot(1, 0, 32'h304, 32'h6, 1, 0, 0, WORD);
      cyc(2'b11);
      clear_heads();
      set_slot(0, 0, 32'h0, 0, 0, 0, 1, 0);
      set_slot(1, 5'd4, 32'h7, 0, 0, 0, 0, 0);
      cyc(2'b01);
      clear_heads();
      set_slot(0, 5'd4, 32'h7, 0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         chk("drain_err", error_status, NO_ERROR);
         cyc(2'b00);
      end
      st_grant = 1'b1;
      cyc(2'b00);
      chk("drain_err1", error_status, NO_ERROR);
      cyc(2'b00);
      chk("halted", error_status, HALTED_ON_WFI);
      cyc(2'b00);
      chk("halted_sticky", error_status, HALTED_ON_WFI);

      // reset in DRAIN with three queued stores
      st_grant = 1'b0;
      reset = 1'b0;
      cyc(2'b00);
      reset = 1'b1;
      clear_heads();
      set_slot(0, 0, 32'h400, 32'h1, 1, 0, 0, WORD);
      set_slot(1, 0, 32'h404, 32'h2, 1, 0, 0, WORD);
      cyc(2'b11);
      clear_heads();
      set_slot(0, 0, 32'h408, 32'h3, 1, 0, 0, WORD);
      set_slot(1, 0, 32'h0, 0, 0, 0, 1, 0);
      cyc(2'b11);
      clear_heads();
      set_slot(0, 5'd5, 32'h9, 0, 0, 0, 0, 0);
      cyc(2'b00);
      reset = 1'b0;
      cyc(2'b00);
      sbq.delete();
      reset = 1'b1;
      set_slot(1, 5'd6, 32'hA, 0, 0, 0, 0, 0);
      #1;
      chk("rr_err", error_status, NO_ERROR);
      chk("rr_wr_en", wr_en, 2'b11);
      cyc(2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
